child_response_collector: RTL and testbench



---
 rtl/child_response_collector.sv | 136 +++++++++++++
 tb/tb_child_response_collector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/child_response_collector.sv
// Gathers one response per child into a registered valid/ready stream, picking
// children round-robin, and closes the round on completion or timeout.
module child_response_collector #(
    parameter int NUM_CHILD = 10,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          round_start,
    input  logic [NUM_CHILD-1:0]          child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0]   child_data,
    output logic [NUM_CHILD-1:0]          child_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(NUM_CHILD)-1:0]  out_idx,
    output logic                          busy,
    output logic                          round_done,
    output logic                          round_timeout,
    output logic [NUM_CHILD-1:0]          missing_mask
);

    localparam int IDX_W = $clog2(NUM_CHILD);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_CHILD-1:0] r_seen;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_abort;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [IDX_W-1:0]     r_out_idx;
    logic [NUM_CHILD-1:0] r_missing;

    logic [NUM_CHILD-1:0] w_elig;
    logic                 w_slot_free;
    logic                 w_grant_vld;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [NUM_CHILD-1:0] w_grant_oh;
    logic [NUM_CHILD-1:0] w_seen_upd;
    logic                 w_all_seen;
    logic                 w_timer_last;
    logic                 w_exit;

    assign w_elig       = child_valid & ~r_seen;
    assign w_slot_free  = !r_out_valid || out_ready;
    assign w_seen_upd   = r_seen | w_grant_oh;
    assign w_all_seen   = &w_seen_upd;
    assign w_timer_last = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_exit       = (r_state == S_DRAIN) && (!r_out_valid || out_ready);

    // Rotating priority search starting at rr_ptr, wrapping past the top child.
    always_comb begin
        int j;
        j           = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (r_state == S_COLLECT && w_slot_free) begin
            for (int k = 0; k < NUM_CHILD; k++) begin
                j = int'(r_rr_ptr) + k;
                if (j >= NUM_CHILD) j = j - NUM_CHILD;
                if (!w_grant_vld && w_elig[j]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = IDX_W'(j);
                end
            end
        end
        w_grant_oh = w_grant_vld ? (NUM_CHILD'(1) << w_grant_idx) : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (round_start) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_all_seen || w_timer_last) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_exit) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_seen      <= '0;
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_abort     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_missing   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && round_start) begin
                r_seen    <= '0;
                r_timer   <= '0;
                r_abort   <= 1'b0;
                r_missing <= '0;
            end
            // A grant on the final timer cycle still lands in seen before the abort decision.
            if (r_state == S_COLLECT) begin
                r_seen  <= w_seen_upd;
                r_timer <= r_timer + TMR_W'(1);
                if (!w_all_seen && w_timer_last) r_abort <= 1'b1;
            end
            if (w_grant_vld) begin
                r_rr_ptr    <= (w_grant_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : w_grant_idx + IDX_W'(1);
                r_out_valid <= 1'b1;
                r_out_data  <= child_data[w_grant_idx*DATA_W +: DATA_W];
                r_out_idx   <= w_grant_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_exit && r_abort) r_missing <= ~r_seen;
        end
    end

    assign child_ready   = w_grant_oh;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_idx       = r_out_idx;
    assign busy          = (r_state != S_IDLE);
    assign round_done    = w_exit && !r_abort;
    assign round_timeout = w_exit && r_abort;
    assign missing_mask  = r_missing;

endmodule

// File: tb/tb_child_response_collector.sv
// Bench for child_response_collector: directed table, corner sequences and
// randomized traffic checked against a round-level reference model.
module tb_child_response_collector;

    localparam int NC = 10;
    localparam int DW = 16;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               round_start;
    logic [NC-1:0]      child_valid;
    logic [NC*DW-1:0]   child_data;
    logic [NC-1:0]      child_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [3:0]         out_idx;
    logic               busy;
    logic               round_done;
    logic               round_timeout;
    logic [NC-1:0]      missing_mask;

    child_response_collector #(.NUM_CHILD(NC), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .round_start(round_start),
        .child_valid(child_valid), .child_data(child_data), .child_ready(child_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .round_done(round_done), .round_timeout(round_timeout),
        .missing_mask(missing_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [NC-1:0] valid;
        logic          rdy;
        logic [NC-1:0] exp_cr;
        logic          exp_ov;
        logic [3:0]    exp_idx;
        logic          exp_done;
        logic          exp_busy;
    } vec_t;

    vec_t tbl[13];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 draining.
    int            m_phase, m_ptr, m_timer, m_oi;
    bit            m_abort, m_ov;
    logic [NC-1:0] m_seen, m_miss;
    logic [DW-1:0] m_od;
    int            e_grant;
    bit            e_exit;
    logic          s_start, s_rdy;
    logic [NC-1:0] s_valid;
    logic [NC*DW-1:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_timer = 0; m_oi = 0;
        m_abort = 0; m_ov = 0; m_seen = '0; m_miss = '0; m_od = '0;
    endtask

    task automatic eval();
        int c;
        @(negedge clk);
        s_start = round_start; s_valid = child_valid; s_rdy = out_ready; s_data = child_data;
        e_grant = -1;
        if (m_phase == 1 && (!m_ov || s_rdy))
            for (int k = 0; k < NC; k++) begin
                c = (m_ptr + k) % NC;
                if (e_grant < 0 && s_valid[c] && !m_seen[c]) e_grant = c;
            end
        e_exit = (m_phase == 2) && (!m_ov || s_rdy);
        chk("child_ready", child_ready, (e_grant >= 0) ? (32'd1 << e_grant) : 32'd0);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_idx", out_idx, m_oi);
        chk("busy", busy, m_phase != 0);
        chk("round_done", round_done, e_exit && !m_abort);
        chk("round_timeout", round_timeout, e_exit && m_abort);
        chk("missing_mask", missing_mask, m_miss);
    endtask

    task automatic model_step();
        case (m_phase)
            0: if (s_start) begin
                m_phase = 1; m_seen = '0; m_timer = 0; m_miss = '0; m_abort = 0;
            end
            1: begin
                if (e_grant >= 0) m_seen[e_grant] = 1'b1;
                if (m_seen == {NC{1'b1}}) m_phase = 2;
                else if (m_timer == TO - 1) begin m_phase = 2; m_abort = 1; end
                m_timer++;
            end
            default: if (e_exit) begin
                m_phase = 0;
                if (m_abort) m_miss = ~m_seen;
            end
        endcase
        if (e_grant >= 0) begin
            m_ov = 1; m_od = s_data[e_grant*DW +: DW]; m_oi = e_grant; m_ptr = (e_grant + 1) % NC;
        end else if (s_rdy) m_ov = 0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        eval();
        advance();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_phase != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("round_closed", busy, 0);
    endtask

    task automatic start_round();
        round_start = 1'b1;
        cycle();
        round_start = 1'b0;
    endtask

    function automatic vec_t mkv(input logic st, input logic [NC-1:0] v, input logic r,
                                 input logic [NC-1:0] cr, input logic ov, input int idx,
                                 input logic dn, input logic bz);
        vec_t x;
        x.start = st; x.valid = v; x.rdy = r; x.exp_cr = cr; x.exp_ov = ov;
        x.exp_idx = 4'(idx); x.exp_done = dn; x.exp_busy = bz;
        return x;
    endfunction

    initial begin
        int cnt_cr4, cnt_acc4, saw_to, saw_done, n;

        tbl[0] = mkv(1, '0, 1, '0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            tbl[i] = mkv(0, {NC{1'b1}}, 1, NC'(1) << (i - 1), i > 1, (i > 1) ? i - 2 : 0, 0, 1);
        tbl[11] = mkv(0, {NC{1'b1}}, 1, '0, 1, 9, 1, 1);
        tbl[12] = mkv(0, '0, 1, '0, 0, 9, 0, 0);

        rst_n = 1'b0; round_start = 1'b0; child_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < NC; i++) child_data[i*DW +: DW] = 16'hA000 + 16'(i);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_child_ready", child_ready, 0);
        chk("rst_missing", missing_mask, 0);
        chk("rst_pulses", {round_done, round_timeout}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All children at once, full throughput.
        for (int i = 0; i < 13; i++) begin
            round_start = tbl[i].start; child_valid = tbl[i].valid; out_ready = tbl[i].rdy;
            eval();
            chk("tbl_child_ready", child_ready, tbl[i].exp_cr);
            chk("tbl_out_valid", out_valid, tbl[i].exp_ov);
            chk("tbl_out_idx", out_idx, tbl[i].exp_idx);
            chk("tbl_round_done", round_done, tbl[i].exp_done);
            chk("tbl_busy", busy, tbl[i].exp_busy);
            advance();
        end

        // Leave rr_ptr at 3 via a round that only sees child 2, then check wrap order.
        start_round();
        child_valid = NC'(1) << 2;
        cycle();
        child_valid = '0;
        run_until_idle(40);
        start_round();
        child_valid = (NC'(1) << 1) | (NC'(1) << 7);
        eval(); chk("rr_first", child_ready, 32'h080); advance();
        eval(); chk("rr_second", child_ready, 32'h002); chk("rr_idx_a", out_idx, 7); advance();
        eval(); chk("rr_idx_b", out_idx, 1); advance();
        child_valid = '0;
        run_until_idle(40);

        // Back-pressure: hold out_ready low with a response pending (rr_ptr is 2).
        start_round();
        child_valid = {NC{1'b1}};
        cycle(); cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            eval();
            chk("stall_idx", out_idx, 3);
            chk("stall_data", out_data, 16'hA003);
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", child_ready, 0);
            advance();
        end
        out_ready = 1'b1;
        eval(); chk("resume_grant", child_ready, 32'h010); advance();
        run_until_idle(40);

        // Child 4 requests for the whole round: accepted once, then stalls.
        start_round();
        child_valid = NC'(1) << 4;
        cnt_cr4 = 0; cnt_acc4 = 0; n = 0;
        while (m_phase != 0 && n < 40) begin
            eval();
            cnt_cr4 += int'(child_ready[4]);
            cnt_acc4 += int'(out_valid && out_ready && out_idx == 4);
            advance();
            n++;
        end
        chk("dup_grants", cnt_cr4, 1);
        chk("dup_forwarded", cnt_acc4, 1);
        start_round();
        eval(); chk("dup_regrant", child_ready, 32'h010); advance();
        child_valid = '0;
        run_until_idle(40);

        // Only children 0..7 respond: timeout with 8 and 9 missing.
        start_round();
        child_valid = 10'h0FF;
        saw_to = 0; saw_done = 0; n = 0;
        while (m_phase != 0 && n < 40) begin
            eval();
            saw_to += int'(round_timeout);
            saw_done += int'(round_done);
            advance();
            n++;
        end
        child_valid = '0;
        eval();
        chk("to_pulses", saw_to, 1);
        chk("to_no_done", saw_done, 0);
        chk("to_missing", missing_mask, 10'h300);
        advance();

        // Reset in the middle of a round with a response pending.
        start_round();
        child_valid = {NC{1'b1}}; out_ready = 1'b0;
        cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_child_ready", child_ready, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        start_round();
        eval(); chk("arst_clean_grant", child_ready, 32'h001); advance();
        run_until_idle(40);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            round_start = ($urandom_range(0, 3) == 0);
            child_valid = NC'($urandom) & NC'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NC; c++) child_data[c*DW +: DW] = DW'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
